vram_fill_arbiter: RTL and testbench

VRAM_FILL_ARBITER -- requirements
Module: vram_fill_arbiter

---
 rtl/vram_fill_arbiter.sv | 156 +++++++++++++++
 tb/tb_vram_fill_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fill_arbiter.sv
// Video-memory write arbiter: fixed-priority CPU pixel writes over a rectangle fill engine.
// Optional macro VRAM_FILL_SWAP_EN normalizes reversed corners instead of treating them as empty.
module vram_fill_arbiter #(
  parameter int COLOR_W = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iCpuWriteEnable,
  input  logic [7:0]         iCpuColumn,
  input  logic [7:0]         iCpuRow,
  input  logic [COLOR_W-1:0] iCpuColor,
  input  logic               iFillValid,
  output logic               oFillReady,
  input  logic [7:0]         iFillCol0,
  input  logic [7:0]         iFillRow0,
  input  logic [7:0]         iFillCol1,
  input  logic [7:0]         iFillRow1,
  input  logic [COLOR_W-1:0] iFillColor,
  output logic               oWriteEnable,
  output logic [15:0]        oWriteAddress,
  output logic [COLOR_W-1:0] oDataOut,
  output logic               oBusy,
  output logic               oFillDone
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [7:0]         col0_q, col0_n;
  logic [7:0]         col1_q, col1_n;
  logic [7:0]         row1_q, row1_n;
  logic [COLOR_W-1:0] color_q, color_n;
  logic [7:0]         cur_col, cur_col_n;
  logic [7:0]         cur_row, cur_row_n;
  logic               we_q, we_n;
  logic [15:0]        addr_q, addr_n;
  logic [COLOR_W-1:0] data_q, data_n;

  logic [7:0] lo_col, hi_col, lo_row, hi_row;
  logic       empty_rect;
  logic       row_end, rect_end;

`ifdef VRAM_FILL_SWAP_EN
  always_comb begin
    lo_col     = (iFillCol0 > iFillCol1) ? iFillCol1 : iFillCol0;
    hi_col     = (iFillCol0 > iFillCol1) ? iFillCol0 : iFillCol1;
    lo_row     = (iFillRow0 > iFillRow1) ? iFillRow1 : iFillRow0;
    hi_row     = (iFillRow0 > iFillRow1) ? iFillRow0 : iFillRow1;
    empty_rect = 1'b0;
  end
`else
  always_comb begin
    lo_col     = iFillCol0;
    hi_col     = iFillCol1;
    lo_row     = iFillRow0;
    hi_row     = iFillRow1;
    empty_rect = (iFillCol0 > iFillCol1) || (iFillRow0 > iFillRow1);
  end
`endif

  // Equality compares before increment keep 255 corners from wrapping to 0.
  assign row_end  = (cur_col == col1_q);
  assign rect_end = row_end && (cur_row == row1_q);

  always_comb begin
    state_n   = state;
    col0_n    = col0_q;
    col1_n    = col1_q;
    row1_n    = row1_q;
    color_n   = color_q;
    cur_col_n = cur_col;
    cur_row_n = cur_row;
    we_n      = 1'b0;
    addr_n    = addr_q;
    data_n    = data_q;

    if (iCpuWriteEnable) begin
      we_n   = 1'b1;
      addr_n = {iCpuColumn, iCpuRow};
      data_n = iCpuColor;
    end

    case (state)
      ST_IDLE: begin
        if (iFillValid) begin
          col0_n    = lo_col;
          col1_n    = hi_col;
          row1_n    = hi_row;
          color_n   = iFillColor;
          cur_col_n = lo_col;
          cur_row_n = lo_row;
          state_n   = empty_rect ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (!iCpuWriteEnable) begin
          we_n   = 1'b1;
          addr_n = {cur_col, cur_row};
          data_n = color_q;
          if (rect_end) begin
            state_n = ST_DONE;
          end else if (row_end) begin
            cur_col_n = col0_q;
            cur_row_n = cur_row + 8'd1;
          end else begin
            cur_col_n = cur_col + 8'd1;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= ST_IDLE;
      col0_q  <= '0;
      col1_q  <= '0;
      row1_q  <= '0;
      color_q <= '0;
      cur_col <= '0;
      cur_row <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_n;
      col0_q  <= col0_n;
      col1_q  <= col1_n;
      row1_q  <= row1_n;
      color_q <= color_n;
      cur_col <= cur_col_n;
      cur_row <= cur_row_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
    end
  end

  assign oFillReady    = (state == ST_IDLE);
  assign oBusy         = (state != ST_IDLE);
  assign oFillDone     = (state == ST_DONE);
  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oDataOut      = data_q;

endmodule

// File: tb/tb_vram_fill_arbiter.sv
// Directed self-checking bench for vram_fill_arbiter; reversed-rectangle expectations
// follow VRAM_FILL_SWAP_EN when the bench is built with the same define.
module tb_vram_fill_arbiter;

  localparam int CW = 3;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          iCpuWriteEnable;
  logic [7:0]    iCpuColumn, iCpuRow;
  logic [CW-1:0] iCpuColor;
  logic          iFillValid;
  logic          oFillReady;
  logic [7:0]    iFillCol0, iFillRow0, iFillCol1, iFillRow1;
  logic [CW-1:0] iFillColor;
  logic          oWriteEnable;
  logic [15:0]   oWriteAddress;
  logic [CW-1:0] oDataOut;
  logic          oBusy, oFillDone;

  vram_fill_arbiter #(.COLOR_W(CW)) dut (
    .Clock(Clock), .Reset(Reset),
    .iCpuWriteEnable(iCpuWriteEnable), .iCpuColumn(iCpuColumn), .iCpuRow(iCpuRow),
    .iCpuColor(iCpuColor), .iFillValid(iFillValid), .oFillReady(oFillReady),
    .iFillCol0(iFillCol0), .iFillRow0(iFillRow0), .iFillCol1(iFillCol1), .iFillRow1(iFillRow1),
    .iFillColor(iFillColor), .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress),
    .oDataOut(oDataOut), .oBusy(oBusy), .oFillDone(oFillDone)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc;
  int done_cnt;
  int done_cyc;
  logic [15:0]   log_addr[$];
  logic [CW-1:0] log_data[$];
  logic [15:0]   exp_addr[$];
  logic [CW-1:0] exp_data[$];

  always @(posedge Clock) cyc = cyc + 1;

  always @(negedge Clock) begin
    if (oWriteEnable) begin
      log_addr.push_back(oWriteAddress);
      log_data.push_back(oDataOut);
    end
    if (oFillDone) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    exp_addr.delete();
    exp_data.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic start_fill(input logic [7:0] c0, input logic [7:0] r0,
                            input logic [7:0] c1, input logic [7:0] r1, input logic [CW-1:0] col);
    clear_log();
    iFillCol0  = c0;
    iFillRow0  = r0;
    iFillCol1  = c1;
    iFillRow1  = r1;
    iFillColor = col;
    iFillValid = 1'b1;
    start_cyc  = cyc;
    @(negedge Clock);
    iFillValid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n);
    int budget;
    budget = 60;
    while (done_cnt < n && budget > 0) begin
      @(negedge Clock);
      budget--;
    end
    check({tag, "_done_seen"}, (done_cnt >= n), 1);
    repeat (4) @(negedge Clock);
  endtask

  task automatic expect_w(input logic [15:0] a, input logic [CW-1:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, log_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), log_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", tag, i), log_data[i], exp_data[i]);
    end
  endtask

  initial begin
    Reset = 1'b0;
    iCpuWriteEnable = 1'b0;
    iCpuColumn = '0;
    iCpuRow = '0;
    iCpuColor = '0;
    iFillValid = 1'b0;
    iFillCol0 = '0; iFillRow0 = '0; iFillCol1 = '0; iFillRow1 = '0;
    iFillColor = '0;
    done_cnt = 0;
    done_cyc = -1;
    repeat (3) @(negedge Clock);
    check("rst_we", oWriteEnable, 0);
    check("rst_addr", oWriteAddress, 0);
    check("rst_data", oDataOut, 0);
    check("rst_busy", oBusy, 0);
    check("rst_done", oFillDone, 0);
    check("rst_ready", oFillReady, 1);
    Reset = 1'b1;
    @(negedge Clock);

    // Plain 3x2 fill.
    start_fill(8'd2, 8'd3, 8'd4, 8'd4, 3'd5);
    check("t1_busy", oBusy, 1);
    check("t1_ready", oFillReady, 0);
    wait_done("t1", 1);
    expect_w(16'h0203, 3'd5); expect_w(16'h0303, 3'd5); expect_w(16'h0403, 3'd5);
    expect_w(16'h0204, 3'd5); expect_w(16'h0304, 3'd5); expect_w(16'h0404, 3'd5);
    check_log("t1");
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_lat", done_cyc - start_cyc, 7);

    // Same fill with two CPU writes interleaved.
    start_fill(8'd2, 8'd3, 8'd4, 8'd4, 3'd5);
    @(negedge Clock);
    iCpuWriteEnable = 1'b1;
    iCpuColumn = 8'd10;
    iCpuRow = 8'd10;
    iCpuColor = 3'd1;
    repeat (2) @(negedge Clock);
    iCpuWriteEnable = 1'b0;
    wait_done("t2", 1);
    expect_w(16'h0203, 3'd5); expect_w(16'h0A0A, 3'd1); expect_w(16'h0A0A, 3'd1);
    expect_w(16'h0303, 3'd5); expect_w(16'h0403, 3'd5); expect_w(16'h0204, 3'd5);
    expect_w(16'h0304, 3'd5); expect_w(16'h0404, 3'd5);
    check_log("t2");
    check("t2_done_cnt", done_cnt, 1);
    check("t2_done_lat", done_cyc - start_cyc, 9);

    // Corner at 255 must not wrap.
    start_fill(8'd254, 8'd255, 8'd255, 8'd255, 3'd6);
    wait_done("t3", 1);
    expect_w(16'hFEFF, 3'd6); expect_w(16'hFFFF, 3'd6);
    check_log("t3");
    check("t3_done_cnt", done_cnt, 1);
    check("t3_done_lat", done_cyc - start_cyc, 3);

    // Reversed rectangle.
    start_fill(8'd5, 8'd5, 8'd3, 8'd3, 3'd7);
    wait_done("t4", 1);
`ifdef VRAM_FILL_SWAP_EN
    for (int r = 3; r <= 5; r++)
      for (int c = 3; c <= 5; c++)
        expect_w({c[7:0], r[7:0]}, 3'd7);
    check("t4_done_lat", done_cyc - start_cyc, 10);
`else
    check("t4_done_lat", done_cyc - start_cyc, 1);
`endif
    check_log("t4");
    check("t4_done_cnt", done_cnt, 1);

    // Reset after three writes of a 4x4 fill.
    start_fill(8'd0, 8'd0, 8'd3, 8'd3, 3'd2);
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("t5_we", oWriteEnable, 0);
    check("t5_addr", oWriteAddress, 0);
    check("t5_data", oDataOut, 0);
    check("t5_busy", oBusy, 0);
    check("t5_done", oFillDone, 0);
    Reset = 1'b1;
    @(negedge Clock);
    check("t5_ready", oFillReady, 1);
    repeat (5) @(negedge Clock);
    expect_w(16'h0000, 3'd2); expect_w(16'h0100, 3'd2); expect_w(16'h0200, 3'd2);
    check_log("t5");
    check("t5_no_done", done_cnt, 0);
    start_fill(8'd1, 8'd1, 8'd1, 8'd1, 3'd4);
    wait_done("t5b", 1);
    expect_w(16'h0101, 3'd4);
    check_log("t5b");

    // Valid held high while busy: second command only once ready returns.
    begin
      int hits;
      int rc[$];
      clear_log();
      iFillCol0 = 8'd0; iFillRow0 = 8'd0; iFillCol1 = 8'd1; iFillRow1 = 8'd0;
      iFillColor = 3'd3;
      iFillValid = 1'b1;
      hits = 0;
      for (int i = 0; i < 30; i++) begin
        if (oFillReady) begin
          hits++;
          rc.push_back(cyc);
        end
        if (hits == 2) break;
        @(negedge Clock);
      end
      @(negedge Clock);
      iFillValid = 1'b0;
      check("t6_accepts", hits, 2);
      if (rc.size() == 2) check("t6_gap", rc[1] - rc[0], 4);
      wait_done("t6", 2);
      expect_w(16'h0000, 3'd3); expect_w(16'h0100, 3'd3);
      expect_w(16'h0000, 3'd3); expect_w(16'h0100, 3'd3);
      check_log("t6");
      check("t6_done_cnt", done_cnt, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
